// File: rtl/pe27_feeder_if.sv
// Bundles the command, memory-read, PE and result channels of pe27_feeder.
// The feeder takes the master modport; the scheduler/memory/PE side takes slave.
interface pe27_feeder_if #(
    parameter int NUM_TAPS = 27,
    parameter int DW       = 8,
    parameter int ADDR_W   = 16,
    parameter int ACC_W    = 24
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W-1:0]        cmd_w_base;
    logic [ADDR_W-1:0]        cmd_x_base;

    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_rd_addr;
    logic [DW-1:0]            mem_rd_data;

    logic                     pe_start;
    logic [NUM_TAPS*DW-1:0]   pe_weights_flat;
    logic [NUM_TAPS*DW-1:0]   pe_inputs_flat;
    logic [ACC_W-1:0]         pe_mac_out;
    logic                     pe_done;

    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic                     res_timeout;
    logic                     busy;

    modport master (
        input  cmd_valid, cmd_w_base, cmd_x_base, mem_rd_data, pe_mac_out, pe_done, res_ready,
        output cmd_ready, mem_rd_en, mem_rd_addr, pe_start, pe_weights_flat, pe_inputs_flat,
               res_valid, res_data, res_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_w_base, cmd_x_base, mem_rd_data, pe_mac_out, pe_done, res_ready,
        input  cmd_ready, mem_rd_en, mem_rd_addr, pe_start, pe_weights_flat, pe_inputs_flat,
               res_valid, res_data, res_timeout, busy
    );
endinterface

// File: rtl/pe27_feeder.sv
// Command-driven operand feeder for pe27_mac: fetches 27 weight and 27 input bytes,
// starts the PE, waits for done under a watchdog and hands back the result.

module pe27_feeder_tap #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);
    logic [DW-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_q <= '0;
        else if (we_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module pe27_feeder #(
    parameter int NUM_TAPS = 27,
    parameter int DW       = 8,
    parameter int ADDR_W   = 16,
    parameter int ACC_W    = 24,
    parameter int TIMEOUT  = 20000
) (
    input  logic          clk,
    input  logic          rst_n,
    pe27_feeder_if.master bus
);
    localparam int NRD = 2 * NUM_TAPS;
    localparam int KW  = $clog2(NRD);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] x_base_q, x_base_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic              res_tmo_q, res_tmo_d;

    // Tag of the read issued last cycle; its data is on mem_rd_data now.
    logic              rd_vld_q;
    logic [KW-1:0]     rd_idx_q;

    logic [NUM_TAPS-1:0]         we_w, we_x;
    logic [NUM_TAPS-1:0][DW-1:0] w_taps, x_taps;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_base_d   = w_base_q;
        x_base_d   = x_base_q;
        wdog_d     = wdog_q;
        res_data_d = res_data_q;
        res_tmo_d  = res_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_base_d = bus.cmd_w_base;
                    x_base_d = bus.cmd_x_base;
                    k_d      = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (k_q == KW'(NRD - 1)) state_d = S_DRAIN;
                else                     k_d     = k_q + KW'(1);
            end
            S_DRAIN: state_d = S_START;
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done wins over an expiring watchdog in the same cycle
                if (bus.pe_done) begin
                    res_data_d = bus.pe_mac_out;
                    res_tmo_d  = 1'b0;
                    state_d    = S_OUT;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_tmo_d  = 1'b1;
                    state_d    = S_OUT;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_OUT: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            w_base_q   <= '0;
            x_base_q   <= '0;
            wdog_q     <= '0;
            res_data_q <= '0;
            res_tmo_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            w_base_q   <= w_base_d;
            x_base_q   <= x_base_d;
            wdog_q     <= wdog_d;
            res_data_q <= res_data_d;
            res_tmo_q  <= res_tmo_d;
            rd_vld_q   <= (state_q == S_FETCH);
            rd_idx_q   <= k_q;
        end
    end

    // Addresses wrap modulo 2^ADDR_W by plain truncating addition.
    always_comb begin
        bus.mem_rd_addr = '0;
        if (state_q == S_FETCH) begin
            if (k_q < KW'(NUM_TAPS)) bus.mem_rd_addr = w_base_q + ADDR_W'(k_q);
            else                     bus.mem_rd_addr = x_base_q + ADDR_W'(k_q - KW'(NUM_TAPS));
        end
    end

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        assign we_w[i] = rd_vld_q && (rd_idx_q == KW'(i));
        assign we_x[i] = rd_vld_q && (rd_idx_q == KW'(NUM_TAPS + i));

        pe27_feeder_tap #(.DW(DW)) u_w (
            .clk  (clk),
            .rst_n(rst_n),
            .we_i (we_w[i]),
            .d_i  (bus.mem_rd_data),
            .q_o  (w_taps[i])
        );

        pe27_feeder_tap #(.DW(DW)) u_x (
            .clk  (clk),
            .rst_n(rst_n),
            .we_i (we_x[i]),
            .d_i  (bus.mem_rd_data),
            .q_o  (x_taps[i])
        );
    end

    assign bus.cmd_ready       = (state_q == S_IDLE);
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.mem_rd_en       = (state_q == S_FETCH);
    assign bus.pe_start        = (state_q == S_START);
    assign bus.res_valid       = (state_q == S_OUT);
    assign bus.res_data        = res_data_q;
    assign bus.res_timeout     = res_tmo_q;
    assign bus.pe_weights_flat = w_taps;
    assign bus.pe_inputs_flat  = x_taps;
endmodule

// File: tb/tb_pe27_feeder.sv
// Randomized scoreboard bench for pe27_feeder: memory model, PE stub and a
// reference model that derives addresses, operands and results from memory contents.
module tb_pe27_feeder;
    localparam int NT   = 27;
    localparam int TOUT = 100;

    typedef struct {
        logic [23:0]  data;
        logic         tmo;
        int           t0;
        int           lat;
        logic [215:0] w;
        logic [215:0] x;
    } res_t;

    typedef struct {
        int           cyc;
        logic [215:0] w;
        logic [215:0] x;
    } start_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    logic [7:0]  mem [0:65535];
    res_t        sb_q[$];
    start_t      st_q[$];
    logic [15:0] addr_q[$];

    int   cur_lat = 1;
    logic cur_hang = 1'b0;
    int   rr_mode = 2;
    logic prev_rv = 1'b0;

    pe27_feeder_if #(.NUM_TAPS(NT), .DW(8), .ADDR_W(16), .ACC_W(24)) bus ();

    pe27_feeder #(.NUM_TAPS(NT), .DW(8), .ADDR_W(16), .ACC_W(24), .TIMEOUT(TOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Synchronous byte memory, one cycle read latency.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

    // PE stub: sums products after cur_lat cycles, or never answers when hung.
    // A bogus done is sometimes thrown into the START cycle, where it must be ignored.
    initial begin
        int           cnt;
        logic [23:0]  acc;
        int           s;
        cnt = 0;
        acc = '0;
        bus.pe_done    = 1'b0;
        bus.pe_mac_out = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pe_done = 1'b0;
            if (!rst_n) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.pe_done    = 1'b1;
                    bus.pe_mac_out = acc;
                end
            end
            if (rst_n && bus.pe_start && !cur_hang) begin
                s = 0;
                for (int i = 0; i < NT; i++)
                    s += int'(bus.pe_weights_flat[i*8 +: 8]) * int'(bus.pe_inputs_flat[i*8 +: 8]);
                acc = 24'(s);
                cnt = cur_lat;
                if ($urandom_range(0, 1) == 1) begin
                    bus.pe_done    = 1'b1;
                    bus.pe_mac_out = 24'h000BAD;
                end
            end
        end
    end

    // res_ready: 0 = random backpressure, 1 = held low, 2 = held high
    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 2)      bus.res_ready = 1'b1;
            else if (rr_mode == 1) bus.res_ready = 1'b0;
            else                   bus.res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every read, start pulse and result is matched against the model's queues.
    always @(negedge clk) begin
        logic [15:0] ea;
        start_t      se;
        res_t        re;
        if (rst_n) begin
            if (bus.mem_rd_en) begin
                chk("rd_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", bus.mem_rd_addr, ea);
                end
            end
            if (bus.pe_start) begin
                chk("start_expected", st_q.size() != 0, 1);
                if (st_q.size() != 0) begin
                    se = st_q.pop_front();
                    chk("start_cycle", cyc, se.cyc);
                    chk("w_flat", bus.pe_weights_flat, se.w);
                    chk("x_flat", bus.pe_inputs_flat, se.x);
                end
            end
            if (bus.res_valid && !prev_rv) begin
                chk("res_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0)
                    chk("res_rise_cycle", cyc, sb_q[0].t0 + 57 + (sb_q[0].tmo ? TOUT : sb_q[0].lat));
            end
            if (bus.res_valid && bus.res_ready && sb_q.size() != 0) begin
                re = sb_q.pop_front();
                chk("res_data", bus.res_data, re.data);
                chk("res_timeout", bus.res_timeout, re.tmo);
                chk("w_flat_held", bus.pe_weights_flat, re.w);
                chk("x_flat_held", bus.pe_inputs_flat, re.x);
            end
        end
        prev_rv = bus.res_valid;
    end

    // Reference model: everything follows from memory contents and the base addresses.
    task automatic push_expect(input logic [15:0] w, input logic [15:0] x, input int lat,
                               input logic hang, input int t0);
        res_t         r;
        start_t       s;
        logic [215:0] wf, xf;
        int           sum;
        sum = 0;
        wf  = '0;
        xf  = '0;
        for (int i = 0; i < NT; i++) begin
            wf[i*8 +: 8] = mem[w + 16'(i)];
            xf[i*8 +: 8] = mem[x + 16'(i)];
            sum += int'(mem[w + 16'(i)]) * int'(mem[x + 16'(i)]);
        end
        for (int i = 0; i < NT; i++) addr_q.push_back(w + 16'(i));
        for (int i = 0; i < NT; i++) addr_q.push_back(x + 16'(i));
        s.cyc = t0 + 56;
        s.w   = wf;
        s.x   = xf;
        st_q.push_back(s);
        r.data = hang ? 24'd0 : 24'(sum);
        r.tmo  = hang;
        r.t0   = t0;
        r.lat  = lat;
        r.w    = wf;
        r.x    = xf;
        sb_q.push_back(r);
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic [15:0] x, input int lat, input logic hang);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_w_base = w;
        bus.cmd_x_base = x;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("cmd_accept", got, 1);
        if (got) begin
            cur_lat  = lat;
            cur_hang = hang;
            push_expect(w, x, lat, hang, cyc);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus.cmd_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_pe_start"}, bus.pe_start, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_timeout"}, bus.res_timeout, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_w_flat"}, bus.pe_weights_flat, 0);
        chk({tag, "_x_flat"}, bus.pe_inputs_flat, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        addr_q.delete();
        st_q.delete();
        sb_q.delete();
        #1;
        chk_reset_vals(tag);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [23:0] held;
        logic        seen;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_w_base = '0;
        bus.cmd_x_base = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;

        // all ones -> 27
        for (int i = 0; i < NT; i++) begin
            mem[16'h0100 + 16'(i)] = 8'd1;
            mem[16'h0200 + 16'(i)] = 8'd1;
        end
        send_cmd(16'h0100, 16'h0200, 1, 1'b0);
        drain();

        // taps 0-8 = 2 x 3, rest 0 -> 54
        for (int i = 0; i < NT; i++) begin
            mem[16'h0400 + 16'(i)] = (i < 9) ? 8'd2 : 8'd0;
            mem[16'h0500 + 16'(i)] = (i < 9) ? 8'd3 : 8'd0;
        end
        send_cmd(16'h0400, 16'h0500, 4, 1'b0);
        drain();

        // ramp weights, input base wraps past 0xFFFF
        for (int i = 0; i < NT; i++) mem[16'h0300 + 16'(i)] = 8'(i);
        send_cmd(16'h0300, 16'hFFF0, 2, 1'b0);
        drain();

        // backpressure: result must hold, a pulsed command must be ignored
        rr_mode = 1;
        send_cmd(16'h0100, 16'h0500, 3, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hold_res_valid_seen", seen, 1);
        held = bus.res_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid  = (i == 3);
            bus.cmd_w_base = 16'h1234;
            bus.cmd_x_base = 16'h4321;
            @(negedge clk);
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_res_data", bus.res_data, held);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rr_mode = 2;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (!bus.res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("release_res_valid_low", seen, 1);
        chk("release_cmd_ready", bus.cmd_ready, 1);
        drain();

        // PE never answers -> watchdog
        send_cmd(16'h0200, 16'h0300, 1, 1'b1);
        drain();

        // reset in FETCH, then a normal command
        send_cmd(16'h0100, 16'h0200, 2, 1'b0);
        repeat (20) @(posedge clk);
        do_reset("rst_fetch");
        send_cmd(16'h0400, 16'h0500, 2, 1'b0);
        drain();

        // reset in WAIT, then a normal command
        send_cmd(16'h0300, 16'h0400, 1, 1'b1);
        repeat (70) @(posedge clk);
        do_reset("rst_wait");
        send_cmd(16'h0100, 16'h0200, 3, 1'b0);
        drain();

        // random bases, latencies and backpressure
        rr_mode = 0;
        for (int t = 0; t < 20; t++)
            send_cmd(16'($urandom), 16'($urandom), $urandom_range(1, 6), 1'b0);
        drain();
        rr_mode = 2;

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
